multu_sequencer: RTL and testbench
==================================

Name: multu_sequencer

Overview:
Multi-cycle controller for the unsigned multiply (MULTU) path of the MIPS core. It accepts operands from the register file when the decoder flags a MULTU. It runs an iterative shift-add over WIDTH cycles and commits the 2*WIDTH-bit product to architectural HI/LO registers. While a multiply is in flight it raises a stall so the core holds the PC and instruction whenever a new MULTU or an MFHI/MFLO read arrives.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH.
CNT_W, $clog2(WIDTH+1), iteration-counter width (derived, do not override).

Ports:
clk  in  1  core clock, all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  decoded MULTU in the current instruction, qualified valid.
srca  in  WIDTH  multiplicand (rs value).
srcb  in  WIDTH  multiplier (rt value).
hilo_read  in  1  current instruction is MFHI or MFLO.
busy  out  1  multiply in progress (state RUN).
stall  out  1  core must hold PC/instruction this cycle.
done  out  1  one-cycle pulse: HI/LO just updated.
hi  out  WIDTH  architectural HI (upper product half).
lo  out  WIDTH  architectural LO (lower product half).

Behaviour:
- Reset: state IDLE, counter 0, working regs 0, hi=0, lo=0, busy=0, stall=0, done=0. Reset mid-RUN aborts the multiply; no done pulse; hi/lo cleared.
- States: IDLE, RUN, DONE. busy=(state==RUN); done=(state==DONE); both decoded from registered state only.
- IDLE or DONE with start=1: latch mcand<=srca, mpl<=srcb, acc<=0, cnt<=WIDTH; go to RUN. Without start: IDLE stays IDLE; DONE returns to IDLE.
- RUN, each cycle:
  - sum = {1'b0,acc} + (mpl[0] ? mcand : 0), computed in WIDTH+1 bits.
  - Shift: acc<=sum[WIDTH:1]; mpl<={sum[0], mpl[WIDTH-1:1]}; cnt<=cnt-1.
- RUN with cnt==1: the shift still happens. On the same edge, hi<=new acc and lo<=new mpl (the final shifted values), and the state goes to DONE.
- Latency: start sampled at edge 0; RUN occupies cycles 1..WIDTH; hi/lo valid and done=1 in cycle WIDTH+1.
- hi/lo keep their previous values for the whole RUN. Working registers are separate from the architectural HI/LO.
- stall = busy & (start | hilo_read), purely combinational. start while busy is not accepted; the core re-presents it after the stall drops, and it is accepted in DONE.
- hilo_read in DONE or IDLE: no stall; reads return the committed values.
- Overflow is impossible: the product always fits in 2*WIDTH bits. The carry into sum[WIDTH] is absorbed by the shift.
- start and hilo_read asserted together in IDLE: start is accepted and there is no stall. A read in the same instruction is illegal in the ISA and needs no special handling.

Decomposition:
- Shared package (mips_pkg) holds:
  - the state enum {IDLE, RUN, DONE};
  - the default WIDTH=32;
  - the MULTU funct constant 6'b011001 and the MFHI/MFLO funct constants, for decoder/sequencer agreement.
- One natural sub-module: multu_step. It is combinational and takes acc, mpl and mcand to produce the next acc and mpl. The sequencer holds the FSM, counter and registers.

Test Plan:
- Basic: srca=3, srcb=5, start for 1 cycle -> busy cycles 1..32; done in cycle 33; hi=0x00000000, lo=0x0000000F.
- Max operands: 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Also 0x80000000 x 2 -> hi=0x00000001, lo=0.
- Busy collision:
  - Second start at cycle 10 with srca=7, srcb=7 -> stall=1 and first product unaffected.
  - Holding start after the stall drops -> accepted in DONE (cycle 33); next done in cycle 66 with lo=49.
- Read during RUN: hilo_read=1 at cycle 5 -> stall=1, hi/lo still the previous result. hilo_read in cycle 33 -> stall=0, new values visible.
- Reset mid-op: reset at cycle 16 of RUN -> next cycle IDLE, hi=lo=0, no done pulse. A fresh 2x2 multiply afterwards gives lo=4.
- Zero operand: srca=0, srcb=0xDEADBEEF -> still 32 RUN cycles; hi=lo=0; done in cycle 33.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: multiply sequencer states, default datapath width,
// and the funct codes the decoder and the sequencer must agree on.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mstate_t;

  localparam int unsigned DEFAULT_WIDTH = 32;

  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

endpackage

// File: rtl/multu_step.sv
// One combinational shift-add iteration of the unsigned multiply:
// add mcand when the multiplier LSB is set, then shift {acc, mpl} right by one.
module multu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] mpl,
  input  logic [WIDTH-1:0] mcand,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] mpl_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;

  always_comb begin
    addend   = mpl[0] ? mcand : '0;
    // Carry lands in sum[WIDTH] and is absorbed by the right shift.
    sum      = {1'b0, acc} + {1'b0, addend};
    acc_next = sum[WIDTH:1];
    mpl_next = {sum[0], mpl[WIDTH-1:1]};
  end

endmodule

// File: rtl/multu_sequencer.sv
// Multi-cycle MULTU controller: runs WIDTH shift-add steps on private working
// registers, then commits the product to architectural HI/LO in one edge.
module multu_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             hilo_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mstate_t          state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mpl;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] mpl_next;

  multu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc      (acc),
    .mpl      (mpl),
    .mcand    (mcand),
    .acc_next (acc_next),
    .mpl_next (mpl_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      mpl   <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= srca;
            mpl   <= srcb;
            acc   <= '0;
            cnt   <= CNT_W'(WIDTH);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc <= acc_next;
          mpl <= mpl_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            hi    <= acc_next;
            lo    <= mpl_next;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  // A start seen while busy is refused; the core re-presents it once the stall drops.
  assign stall = busy & (start | hilo_read);

endmodule

// File: tb/tb_multu_sequencer.sv
// Scoreboard bench for multu_sequencer: stimulus queues expected {hi,lo}, a monitor
// compares whenever done pulses; latency, stall and reset behaviour checked inline.
module tb_multu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        hilo_read;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [63:0] sb_q[$];

  multu_sequencer #(
    .WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .srca      (srca),
    .srcb      (srcb),
    .hilo_read (hilo_read),
    .busy      (busy),
    .stall     (stall),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives start across edge 0; returns in cycle 1.
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    srca  = a;
    srcb  = b;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic mul(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el);
    int bc;
    bc = 0;
    sb_q.push_back({eh, el});
    issue(a, b);
    while (!done && cyc < 200) begin
      bc += int'(busy);
      tick();
    end
    chk({name, "_done_cycle"}, 64'(cyc), 64'd33);
    chk({name, "_busy_cycles"}, 64'(bc), 64'd32);
    tick();
    chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got hi=0x%0h lo=0x%0h expected no done", hi, lo);
      end else begin
        chk("product", {hi, lo}, sb_q.pop_front());
      end
    end
  end

  initial begin
    int bad;
    reset     = 1'b1;
    start     = 1'b0;
    srca      = '0;
    srcb      = '0;
    hilo_read = 1'b0;
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    tick();

    mul("basic", 32'd3, 32'd5, 32'h0, 32'hF);

    // Read during RUN stalls and sees the old result; read in DONE sees the new one.
    sb_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    while (cyc < 5) tick();
    hilo_read = 1'b1;
    #1;
    chk("read_run_stall", 64'(stall), 64'd1);
    chk("read_run_old_hilo", {hi, lo}, {32'h0, 32'hF});
    hilo_read = 1'b0;
    while (!done && cyc < 200) tick();
    chk("max_done_cycle", 64'(cyc), 64'd33);
    hilo_read = 1'b1;
    #1;
    chk("read_done_stall", 64'(stall), 64'd0);
    chk("read_done_new_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    hilo_read = 1'b0;
    tick();

    mul("msb_x2", 32'h8000_0000, 32'd2, 32'h1, 32'h0);

    // Second start arrives mid-run and is held until it is accepted in DONE.
    sb_q.push_back({32'h0, 32'hF});
    issue(32'd3, 32'd5);
    while (cyc < 10) tick();
    srca  = 32'd7;
    srcb  = 32'd7;
    start = 1'b1;
    #1;
    chk("coll_stall", 64'(stall), 64'd1);
    bad = 0;
    while (!done && cyc < 200) begin
      if (!stall) bad++;
      tick();
    end
    chk("coll_first_done_cycle", 64'(cyc), 64'd33);
    chk("coll_stall_held", 64'(bad), 64'd0);
    chk("coll_no_stall_in_done", 64'(stall), 64'd0);
    sb_q.push_back({32'h0, 32'd49});
    tick();
    start = 1'b0;
    while (!done && cyc < 200) tick();
    chk("coll_second_done_cycle", 64'(cyc), 64'd66);
    tick();

    // Reset mid-run: abort without a done pulse; monitor flags any stray done.
    issue(32'd9, 32'd9);
    while (cyc < 16) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    repeat (40) tick();
    mul("after_abort", 32'd2, 32'd2, 32'h0, 32'h4);

    mul("zero", 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
